// File: rtl/mantissa_cal_pipe_pkg.sv
// Types and helpers for the mantissa add/subtract pipeline: the sign-decision
// context carried between stages and the rule that picks the result sign.
`ifndef FP_DEFINES_SV
`include "fp_defines.sv"
`endif

package mantissa_cal_pipe_pkg;

   typedef struct packed {
      logic sign_same;
      logic a_large;
      logic aligned_sign;
      logic rdn;
   } sign_ctl_t;

   // An exact cancellation takes its sign from the rounding mode alone.
   function automatic logic result_sign(input sign_ctl_t ctl, input logic zero);
      logic s;
      if (ctl.sign_same)    s = ctl.aligned_sign;
      else if (zero)        s = ctl.rdn;
      else if (ctl.a_large) s = ctl.aligned_sign;
      else                  s = ~ctl.aligned_sign;
      return s;
   endfunction

   function automatic logic op_of(input logic sign_same);
      return sign_same ? `ADD : `SUB;
   endfunction

endpackage

// File: rtl/fp_defines.sv
// Shared floating-point format codes, field-length helpers and operation codes
// used across the FP datapath.
`ifndef FP_DEFINES_SV
`define FP_DEFINES_SV

`define FP16 0
`define BF16 1
`define FP32 2
`define FP64 3

`define GET_MANTISSA_LEN(fmt) (((fmt) == `FP64) ? 52 : ((fmt) == `FP32) ? 23 : ((fmt) == `BF16) ? 7 : 10)
`define GET_PROTECT_LEN(fmt) 3

`define ADD 1'b0
`define SUB 1'b1

`define RDN 3'b010

`endif

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input counts as WIDTH.
module fp_lzc #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      // NOTE: the default assigned before the loop keeps this purely combinational (no latch).
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/mantissa_cal_pipe.sv
// Mantissa add/subtract with result sign, leading-zero count and zero flag,
// in a one- or two-stage valid/ready pipeline.
`ifndef FP_DEFINES_SV
`include "fp_defines.sv"
`endif

module mantissa_cal_pipe
   import mantissa_cal_pipe_pkg::*;
#(
   parameter  int data_format = `FP32,
   parameter  int PIPE_DEPTH  = 2,
   localparam int M           = `GET_MANTISSA_LEN(data_format),
   localparam int P           = `GET_PROTECT_LEN(data_format),
   localparam int W           = M + P + 1,
   parameter  int LZC_W       = $clog2(W + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_sign,
   input  logic             b_sign,
   input  logic             aligned_sign,
   input  logic [W-1:0]     a_mant,
   input  logic [W-1:0]     b_mant,
   input  logic [2:0]       rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W:0]       cal_result,
   output logic             cal_sign,
   output logic             effective_op,
   output logic [LZC_W-1:0] lzc,
   output logic             is_zero
);

   logic         a_large_in;
   logic [W-1:0] big_in, small_in;
   sign_ctl_t    ctl_in;

   // Swap so the subtraction below never goes negative.
   always_comb begin
      a_large_in = (a_mant >= b_mant);
      big_in     = a_large_in ? a_mant : b_mant;
      small_in   = a_large_in ? b_mant : a_mant;
      ctl_in     = '{sign_same:    (a_sign == b_sign),
                     a_large:      a_large_in,
                     aligned_sign: aligned_sign,
                     rdn:          (rm == `RDN)};
   end

   logic [W-1:0] big_q, small_q;
   sign_ctl_t    ctl_q;
   logic         front_valid;
   logic         s2_valid;
   logic         s2_ready;

   assign s2_ready = ~s2_valid | out_ready;

   generate
      if (PIPE_DEPTH == 1) begin : g_one_stage
         assign big_q       = big_in;
         assign small_q     = small_in;
         assign ctl_q       = ctl_in;
         assign front_valid = in_valid;
         assign in_ready    = s2_ready;
      end else begin : g_two_stage
         logic         s1_valid;
         logic         s1_ready;
         logic [W-1:0] s1_big, s1_small;
         sign_ctl_t    s1_ctl;

         assign s1_ready = ~s1_valid | s2_ready;

         always_ff @(posedge clk) begin
            if (rst)           s1_valid <= 1'b0;
            else if (s1_ready) s1_valid <= in_valid;
         end

         // NOTE: the stage-1 payload is qualified by s1_valid, so it carries no reset.
         always_ff @(posedge clk) begin
            if (in_valid && s1_ready) begin
               s1_big   <= big_in;
               s1_small <= small_in;
               s1_ctl   <= ctl_in;
            end
         end

         assign big_q       = s1_big;
         assign small_q     = s1_small;
         assign ctl_q       = s1_ctl;
         assign front_valid = s1_valid;
         assign in_ready    = s1_ready;
      end
   endgenerate

   logic [W:0]       sum_d;
   logic             zero_d;
   logic [LZC_W-1:0] lzc_d;

   assign sum_d  = ctl_q.sign_same ? ({1'b0, big_q} + {1'b0, small_q})
                                   : ({1'b0, big_q} - {1'b0, small_q});
   assign zero_d = (sum_d == '0);

   fp_lzc #(
      .WIDTH (W + 1),
      .CNT_W (LZC_W)
   ) u_lzc (
      .value (sum_d),
      .count (lzc_d)
   );

   // Result registers reset to zero because they drive the outputs directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid     <= 1'b0;
         cal_result   <= '0;
         cal_sign     <= 1'b0;
         effective_op <= `ADD;
         lzc          <= '0;
         is_zero      <= 1'b0;
      end else if (s2_ready) begin
         s2_valid <= front_valid;
         if (front_valid) begin
            cal_result   <= sum_d;
            cal_sign     <= result_sign(ctl_q, zero_d);
            effective_op <= op_of(ctl_q.sign_same);
            lzc          <= lzc_d;
            is_zero      <= zero_d;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule

// File: tb/tb_mantissa_cal_pipe.sv
// Randomised and directed bench for mantissa_cal_pipe over FP32/FP16 and both
// pipeline depths, scored against a queue-based arithmetic reference model.
`ifndef FP_DEFINES_SV
`include "fp_defines.sv"
`endif

module tb_mantissa_cal_pipe;

   localparam int NCFG = 4;

   typedef struct {
      logic [63:0] res;
      logic        sign;
      logic        op;
      logic        zero;
      int          lzc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int n_done      = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain signed-magnitude arithmetic and a bit-length count.
   function automatic exp_t ref_result(input int w, input logic as, input logic bs,
                                       input logic als, input longint unsigned a,
                                       input longint unsigned b, input logic [2:0] r);
      exp_t            e;
      longint unsigned v;
      int              nbits;
      if (as == bs) begin
         e.res  = a + b;
         e.sign = als;
         e.op   = `ADD;
      end else begin
         e.res  = (a >= b) ? a - b : b - a;
         e.op   = `SUB;
         if (e.res == 0) e.sign = (r == `RDN);
         else            e.sign = (a >= b) ? als : ~als;
      end
      e.zero = (e.res == 0);
      nbits  = 0;
      v      = e.res;
      while (v != 0) begin
         nbits++;
         v = v >> 1;
      end
      e.lzc = w + 1 - nbits;
      return e;
   endfunction

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int CFG   = gi;
      localparam int FMT   = (gi < 2) ? `FP32 : `FP16;
      localparam int DEPTH = (gi % 2) + 1;
      localparam int W     = `GET_MANTISSA_LEN(FMT) + `GET_PROTECT_LEN(FMT) + 1;
      localparam int LZC_W = $clog2(W + 2);

      logic             rst, in_valid, in_ready, out_valid, out_ready;
      logic             a_sign, b_sign, aligned_sign;
      logic [W-1:0]     a_mant, b_mant;
      logic [2:0]       rm;
      logic [W:0]       cal_result;
      logic             cal_sign, effective_op, is_zero;
      logic [LZC_W-1:0] lzc;

      exp_t q[$];

      mantissa_cal_pipe #(
         .data_format (FMT),
         .PIPE_DEPTH  (DEPTH)
      ) dut (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid),
         .in_ready     (in_ready),
         .a_sign       (a_sign),
         .b_sign       (b_sign),
         .aligned_sign (aligned_sign),
         .a_mant       (a_mant),
         .b_mant       (b_mant),
         .rm           (rm),
         .out_valid    (out_valid),
         .out_ready    (out_ready),
         .cal_result   (cal_result),
         .cal_sign     (cal_sign),
         .effective_op (effective_op),
         .lzc          (lzc),
         .is_zero      (is_zero)
      );

      function automatic string tg(input string s);
         return $sformatf("cfg%0d(depth%0d,W%0d)/%s", CFG, DEPTH, W, s);
      endfunction

      task automatic push();
         q.push_back(ref_result(W, a_sign, b_sign, aligned_sign, a_mant, b_mant, rm));
      endtask

      task automatic load_random();
         a_sign       = 1'($urandom);
         b_sign       = 1'($urandom);
         aligned_sign = 1'($urandom);
         a_mant       = W'($urandom);
         b_mant       = ($urandom_range(0, 3) == 0) ? a_mant : W'($urandom);
         rm           = ($urandom_range(0, 1) == 0) ? `RDN : 3'($urandom);
      endtask

      task automatic check_reset_outputs();
         check(tg("rst out_valid"),    64'(out_valid),    64'd0);
         check(tg("rst cal_result"),   64'(cal_result),   64'd0);
         check(tg("rst cal_sign"),     64'(cal_sign),     64'd0);
         check(tg("rst effective_op"), 64'(effective_op), 64'(`ADD));
         check(tg("rst lzc"),          64'(lzc),          64'd0);
         check(tg("rst is_zero"),      64'(is_zero),      64'd0);
         check(tg("rst in_ready"),     64'(in_ready),     64'd1);
      endtask

      task automatic drive(input logic as, input logic bs, input logic als,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] r);
         bit acc = 1'b0;
         a_sign = as; b_sign = bs; aligned_sign = als;
         a_mant = a;  b_mant = b;  rm = r;
         in_valid = 1'b1;
         for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) push();
            #1;
         end
         in_valid = 1'b0;
         check(tg("accepted"), 64'(acc), 64'd1);
      endtask

      // One isolated transfer with out_ready high: checks exact latency and fields.
      task automatic single(input logic as, input logic bs, input logic als,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] r,
                            input logic [63:0] x_res, input logic x_sign, input logic x_op,
                            input logic x_zero, input int x_lzc);
         drive(as, bs, als, a, b, r);
         for (int k = 1; k < DEPTH; k++) begin
            @(negedge clk);
            check(tg("early out_valid"), 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
         end
         @(negedge clk);
         check(tg("latency out_valid"), 64'(out_valid),    64'd1);
         check(tg("dir cal_result"),    64'(cal_result),   x_res);
         check(tg("dir cal_sign"),      64'(cal_sign),     64'(x_sign));
         check(tg("dir effective_op"),  64'(effective_op), 64'(x_op));
         check(tg("dir is_zero"),       64'(is_zero),      64'(x_zero));
         check(tg("dir lzc"),           64'(lzc),          64'(x_lzc));
         @(posedge clk);
         #1;
      endtask

      task automatic stream(input int n, input bit toggle);
         bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
         int sent = 0;
         bit acc;
         for (int cyc = 0; cyc < 4000 && sent < n; cyc++) begin
            out_ready = toggle ? pat[cyc % 4] : ($urandom_range(0, 3) != 0);
            if (!in_valid && (toggle || $urandom_range(0, 2) != 0)) begin
               load_random();
               in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) begin
               push();
               sent++;
            end
            #1;
            if (acc) in_valid = 1'b0;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         check(tg("stream sent"), 64'(sent), 64'(n));
         for (int k = 0; k < 20 && q.size() != 0; k++) begin
            @(posedge clk);
            #1;
         end
         check(tg("drain"), 64'(q.size()), 64'd0);
      endtask

      // Scoreboard: FIFO order, occupancy-based in_ready, and hold while stalled.
      initial begin
         exp_t             e;
         bit               hold_pending = 1'b0;
         logic [W:0]       h_res;
         logic             h_sign, h_op, h_zero;
         logic [LZC_W-1:0] h_lzc;
         forever begin
            @(negedge clk);
            if (rst) begin
               hold_pending = 1'b0;
            end else begin
               check(tg("in_ready"), 64'(in_ready), 64'((q.size() < DEPTH) || out_ready));
               if (hold_pending) begin
                  check(tg("hold out_valid"),    64'(out_valid),    64'd1);
                  check(tg("hold cal_result"),   64'(cal_result),   64'(h_res));
                  check(tg("hold cal_sign"),     64'(cal_sign),     64'(h_sign));
                  check(tg("hold effective_op"), 64'(effective_op), 64'(h_op));
                  check(tg("hold is_zero"),      64'(is_zero),      64'(h_zero));
                  check(tg("hold lzc"),          64'(lzc),          64'(h_lzc));
               end
               if (out_valid) begin
                  if (q.size() == 0) begin
                     check(tg("unexpected out_valid"), 64'(out_valid), 64'd0);
                  end else if (out_ready) begin
                     e = q.pop_front();
                     check(tg("cal_result"),   64'(cal_result),   e.res);
                     check(tg("cal_sign"),     64'(cal_sign),     64'(e.sign));
                     check(tg("effective_op"), 64'(effective_op), 64'(e.op));
                     check(tg("is_zero"),      64'(is_zero),      64'(e.zero));
                     check(tg("lzc"),          64'(lzc),          64'(e.lzc));
                  end
               end
               hold_pending = out_valid && !out_ready;
               h_res  = cal_result;
               h_sign = cal_sign;
               h_op   = effective_op;
               h_zero = is_zero;
               h_lzc  = lzc;
            end
         end
      end

      initial begin
         logic [W-1:0] top_bit;
         top_bit = {1'b1, {(W - 1){1'b0}}};
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
         a_sign = 1'b0; b_sign = 1'b0; aligned_sign = 1'b0;
         a_mant = '0; b_mant = '0; rm = 3'd0;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         check_reset_outputs();
         @(posedge clk);
         #1;

         // Equal-sign carry out of the top bit.
         single(1'b0, 1'b0, 1'b1, top_bit, top_bit, 3'd0,
                64'(1) << W, 1'b1, `ADD, 1'b0, 0);
         // Exact cancellation: sign follows the rounding mode.
         single(1'b0, 1'b1, 1'b0, W'(5), W'(5), `RDN,
                64'd0, 1'b1, `SUB, 1'b1, W + 1);
         single(1'b0, 1'b1, 1'b0, W'(5), W'(5), 3'd0,
                64'd0, 1'b0, `SUB, 1'b1, W + 1);
         // Smaller a: operands swap and the sign flips.
         single(1'b0, 1'b1, 1'b0, W'(3), W'(8), 3'd0,
                64'd5, 1'b1, `SUB, 1'b0, W - 2);

         stream(8, 1'b1);

         // Reset with results in flight: they must vanish.
         out_ready = 1'b0;
         for (int k = 0; k < 2; k++) begin
            bit acc;
            load_random();
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) push();
            #1;
         end
         in_valid = 1'b0;
         rst      = 1'b1;
         @(posedge clk);
         q.delete();
         #1 rst = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         check_reset_outputs();
         @(posedge clk);
         #1;

         stream(300, 1'b0);
         n_done++;
      end
   end

   initial begin
      fork
         wait (n_done == NCFG);
         #500000;
      join_any
      disable fork;
      check("all configurations finished", 64'(n_done), 64'(NCFG));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mantissa_cal_pipe.md
MANTISSA_CAL_PIPE -- requirements
Module: mantissa_cal_pipe

Interface
REQ-001 Parameter data_format, default `FP32, selects the format; M = `GET_MANTISSA_LEN(data_format), P = `GET_PROTECT_LEN(data_format), W = M+P+1.
REQ-002 Parameter PIPE_DEPTH, default 2, sets the number of register stages; legal values are 1 and 2.
REQ-003 Parameter LZC_W, default $clog2(W+2), sets the width of the leading-zero count.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  an operand set is presented.
REQ-007 in_ready  output  1  the block accepts the operand set this cycle.
REQ-008 a_sign, b_sign, aligned_sign  input  1 each  operand signs and the sign after exponent alignment.
REQ-009 a_mant  input  W  aligned mantissa of the larger-exponent operand.
REQ-010 b_mant  input  W  aligned mantissa of the smaller-exponent operand.
REQ-011 rm  input  3  rounding mode; value 3'b010 (RDN) is the only value with special behaviour.
REQ-012 out_valid  output  1  the result is valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 cal_result  output  W+1  magnitude result, with the MSB as carry.
REQ-015 cal_sign  output  1  sign of the result.
REQ-016 effective_op  output  1  `ADD or `SUB.
REQ-017 lzc  output  LZC_W  number of leading zeros of cal_result, counted from the MSB.
REQ-018 is_zero  output  1  cal_result equals zero.

Function
REQ-019 The transfer rule is: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-020 Arithmetic: when the signs are equal, the result is {0,a}+{0,b} and effective_op is `ADD.
REQ-021 Otherwise, with a_mant >= b_mant, the result is {0,a}-{0,b}.
REQ-022 Otherwise, the result is {0,b}-{0,a}, and effective_op is `SUB.
REQ-023 The sign is aligned_sign for equal signs.
REQ-024 For an exact zero under `SUB, the sign is (rm==RDN).
REQ-025 When a_mant >= b_mant, the sign is aligned_sign.
REQ-026 Otherwise, the sign is ~aligned_sign.
REQ-027 Stage 1 (PIPE_DEPTH=2) registers the operand swap, sign_same, a_large and the decided sign inputs.
REQ-028 Stage 2 registers the sum or difference, lzc, is_zero and cal_sign.
REQ-029 PIPE_DEPTH=1 collapses both stages into one register.
REQ-030 Latency from input transfer to out_valid is exactly PIPE_DEPTH cycles when out_ready is held high.
REQ-031 Throughput is one result per cycle with no bubbles while out_ready is high.
REQ-032 The per-stage ready is: stage k accepts when it is empty or its contents advance this cycle; in_ready is the ready of stage 1, and may combinationally depend on out_ready.
REQ-033 Stall: while out_valid=1 and out_ready=0, every output and every occupied stage holds its value unchanged.
REQ-034 Data in an empty stage is don't-care; only its valid bit is reset.
REQ-035 On a simultaneous output transfer and input transfer with a full pipe, the pipe shifts with no loss and no duplication.
REQ-036 lzc equals W+1 when the result is zero; the value is otherwise in the range 0..W.
REQ-037 An equal-sign carry gives lzc=0.
REQ-038 Output ordering is strictly FIFO.

Reset
REQ-039 While rst is high at a clock edge, all stage valid bits clear: out_valid=0, cal_result=0, cal_sign=0, effective_op=`ADD, lzc=0, is_zero=0.
REQ-040 in_ready is 1 in the first cycle after reset is released.
REQ-041 Reset asserted mid-operation discards all in-flight results; no output transfer occurs in the reset cycle.

Structure
REQ-042 `FP32, `GET_MANTISSA_LEN, `GET_PROTECT_LEN, `ADD, `SUB and the RDN code live in the shared defines header; the module includes that header and redefines none of them.
REQ-043 Leading-zero counting is a sub-module fp_lzc, parameterised on width, and is purely combinational.

Verification
REQ-044 Scenario 1: a_sign=b_sign=0, a_mant=b_mant=2^(W-1), out_ready=1 -> after PIPE_DEPTH cycles, cal_result=2^W, effective_op=`ADD, lzc=0, cal_sign=aligned_sign.
REQ-045 Scenario 2: a_sign=0, b_sign=1, a_mant=b_mant=5, rm=RDN -> cal_result=0, is_zero=1, cal_sign=1, lzc=W+1; with rm=0 the same inputs give cal_sign=0.
REQ-046 Scenario 3: a_sign=0, b_sign=1, a_mant=3, b_mant=8, aligned_sign=0 -> cal_result=5, cal_sign=1, effective_op=`SUB, lzc=W-2.
REQ-047 Scenario 4: a stream of 8 back-to-back transfers with out_ready toggling 1,0,0,1 -> all 8 results appear in order, no loss, outputs held stable while stalled, in_ready low while the pipe is full and stalled.
REQ-048 Scenario 5: rst pulsed for one cycle with 2 results in flight -> the next cycle shows out_valid=0 and all outputs at reset values, and neither discarded result ever appears.
REQ-049 Scenario 6: randomised operands for both PIPE_DEPTH values and for `FP32 and one other format, checked against the REQ-020..REQ-026 reference model.
